mult_seq_responder: RTL

//  Signed 16x16 multiplier; the DUT side of the mult req/ack protocol driven by the mult BFM.

---
 rtl/mult_pkg.sv | 18 +
 rtl/mult_shift_add_core.sv | 57 +++++
 rtl/mult_seq_responder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types, constants and helpers for the sequential signed multiplier.
package mult_pkg;

    localparam int unsigned DATA_W_DEF   = 16;
    localparam int unsigned PARITY_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Narrower vectors are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic parity(input logic [PARITY_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/mult_shift_add_core.sv
// Unsigned iterative shift-add multiplier: one multiplier bit per clock after start.
// done is a strobe marking the edge that performs the final iteration.
module mult_shift_add_core #(
    parameter int unsigned W      = 17,
    parameter int unsigned N_ITER = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     mcand,
    input  logic [W-1:0]     mplier,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   product
);

    localparam int unsigned PW    = 2 * W;
    localparam int unsigned CNT_W = $clog2(N_ITER + 1);

    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand_sh;
    logic [W-1:0]     mplier_sh;
    logic [CNT_W-1:0] cnt;
    logic             last_c;

    assign last_c  = busy && (cnt == CNT_W'(N_ITER - 1));
    assign done    = last_c;
    assign product = acc;

    // Accumulate the shifted multiplicand for every set multiplier bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            mcand_sh  <= '0;
            mplier_sh <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
        end else if (start) begin
            acc       <= '0;
            mcand_sh  <= PW'(mcand);
            mplier_sh <= mplier;
            cnt       <= '0;
            busy      <= 1'b1;
        end else if (busy) begin
            if (mplier_sh[0]) begin
                acc <= acc + mcand_sh;
            end
            mcand_sh  <= mcand_sh << 1;
            mplier_sh <= mplier_sh >> 1;
            cnt       <= cnt + CNT_W'(1);
            if (last_c) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mult_seq_responder.sv
// Signed DATA_W x DATA_W multiplier answering the mult req/ack protocol.
// Optional operand parity checking is enabled with `MULT_ARG_PARITY_CHECK_EN.
module mult_seq_responder
    import mult_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic [DATA_W-1:0]     arg_a,
    input  logic                  arg_a_parity,
    input  logic [DATA_W-1:0]     arg_b,
    input  logic                  arg_b_parity,
    output logic                  ack,
    output logic [2*DATA_W-1:0]   result,
    output logic                  result_parity,
    output logic                  result_rdy,
    output logic                  arg_parity_error
);

    localparam int unsigned MAG_W  = DATA_W + 1;
    localparam int unsigned PROD_W = 2 * MAG_W;
    localparam int unsigned RES_W  = 2 * DATA_W;

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_CALC = 2'(CALC);
    localparam logic [1:0] ST_DONE = 2'(DONE);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic              capture_c;
    logic              start_c;
    logic              finish_c;
    logic              bad_par_c;
    logic              neg_q;
    logic              bad_q;
    logic [MAG_W-1:0]  a_ext_c;
    logic [MAG_W-1:0]  b_ext_c;
    logic [MAG_W-1:0]  a_mag_c;
    logic [MAG_W-1:0]  b_mag_c;
    logic              unused_core_busy;
    logic              core_done;
    logic [PROD_W-1:0] core_product;
    logic [PROD_W-1:0] prod_signed_c;
    logic [RES_W-1:0]  res_d;

`ifdef MULT_ARG_PARITY_CHECK_EN
    assign bad_par_c = (parity(PARITY_MAX_W'(arg_a)) != arg_a_parity) ||
                       (parity(PARITY_MAX_W'(arg_b)) != arg_b_parity);
`else
    logic unused_parity_c;
    assign unused_parity_c = arg_a_parity ^ arg_b_parity;
    assign bad_par_c       = 1'b0;
`endif

    // Sign-extend one bit so the magnitude of the most negative operand fits.
    assign a_ext_c = {arg_a[DATA_W-1], arg_a};
    assign b_ext_c = {arg_b[DATA_W-1], arg_b};
    assign a_mag_c = arg_a[DATA_W-1] ? (~a_ext_c + MAG_W'(1)) : a_ext_c;
    assign b_mag_c = arg_b[DATA_W-1] ? (~b_ext_c + MAG_W'(1)) : b_ext_c;

    mult_shift_add_core #(
        .W      (MAG_W),
        .N_ITER (DATA_W)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_c),
        .mcand   (a_mag_c),
        .mplier  (b_mag_c),
        .busy    (unused_core_busy),
        .done    (core_done),
        .product (core_product)
    );

    assign prod_signed_c = neg_q ? (~core_product + PROD_W'(1)) : core_product;
    assign res_d         = bad_q ? '0 : RES_W'(prod_signed_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and the per-cycle strobes that drive capture, core start and completion.
    always_comb begin
        state_d   = state_q;
        capture_c = 1'b0;
        start_c   = 1'b0;
        finish_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    capture_c = 1'b1;
                    if (bad_par_c) begin
                        state_d = ST_DONE;
                    end else begin
                        start_c = 1'b1;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (core_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                finish_c = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered protocol outputs; result fields hold until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack              <= 1'b0;
            result_rdy       <= 1'b0;
            result           <= '0;
            result_parity    <= 1'b0;
            arg_parity_error <= 1'b0;
            neg_q            <= 1'b0;
            bad_q            <= 1'b0;
        end else begin
            ack        <= capture_c;
            result_rdy <= finish_c;
            if (capture_c) begin
                neg_q <= arg_a[DATA_W-1] ^ arg_b[DATA_W-1];
                bad_q <= bad_par_c;
            end
            if (finish_c) begin
                result           <= res_d;
                result_parity    <= parity(PARITY_MAX_W'(res_d));
                arg_parity_error <= bad_q;
            end
        end
    end

endmodule
